// File: rtl/fetch_queue_stage_pkg.sv
// rtl/fetch_queue_stage_pkg.sv - shared fetch-stage types and the link-register test
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/fetch_queue_stage_ras.sv
// rtl/fetch_queue_stage_ras.sv - circular return-address stack with saturating occupancy
module fetch_ras #(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        valid
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [31:0]   r_stack [RAS_DEPTH];
  logic [PW-1:0] r_sp;
  logic [PW:0]   r_cnt;
  logic [PW-1:0] w_top_idx;
  logic          w_pop_ok;

  assign w_top_idx = r_sp - 1'b1;
  assign w_pop_ok  = pop && (r_cnt != '0);
  assign top       = r_stack[w_top_idx];
  assign valid     = (r_cnt != '0);

  // Pop-then-push collapses into overwriting the current top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_stack[i] <= '0;
    end else if (push && w_pop_ok) begin
      r_stack[w_top_idx] <= push_data;
    end else if (push) begin
      r_stack[r_sp] <= push_data;
      r_sp          <= r_sp + 1'b1;
      if (r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
    end else if (w_pop_ok) begin
      r_sp  <= w_top_idx;
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - fetch stage with decoupling queue and next-PC prediction
// FETCH_RAS_EN enables return-address-stack prediction for JALR returns.
module fetch_queue_stage
  import rv32i_types::*;
#(
  parameter int          QDEPTH    = 4,
  parameter int          RAS_DEPTH = 8,
  parameter logic [31:0] RESET_PC  = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_flush,
  input  logic [31:0] pc_mux_out,
  input  logic        pred_hit,
  input  logic [31:0] bht_out,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_resp,
  output logic [31:0] i_mem_addr,
  output logic        i_mem_read,
  input  logic        deq_ready,
  output logic        deq_valid,
  output logic [31:0] deq_inst,
  output logic [31:0] deq_pc,
  output logic [31:0] deq_pred_pc
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);

  fetch_state_t  r_state, w_state_nxt;
  fetch_entry_t  r_q [QDEPTH];
  logic [31:0]   r_pc, r_drop_addr;
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count, w_count_nxt;
  logic          w_enq, w_deq, w_is_jal, w_ret_hit;
  logic [31:0]   w_pc4, w_jal_tgt, w_next_pc, w_ras_top;

  assign w_is_jal  = (i_mem_rdata[6:0] == OP_JAL);
  assign w_pc4     = r_pc + 32'd4;
  assign w_jal_tgt = r_pc + {{12{i_mem_rdata[31]}}, i_mem_rdata[19:12], i_mem_rdata[20],
                             i_mem_rdata[30:21], 1'b0};
  assign w_enq     = i_mem_resp && (r_state == REQ) && !br_flush;
  assign w_deq     = deq_valid && deq_ready && !br_flush;

`ifdef FETCH_RAS_EN
  logic w_is_jalr, w_rd_link, w_rs1_link, w_ras_valid;
  assign w_is_jalr  = (i_mem_rdata[6:0] == OP_JALR);
  assign w_rd_link  = is_link(i_mem_rdata[11:7]);
  assign w_rs1_link = is_link(i_mem_rdata[19:15]);
  assign w_ret_hit  = w_is_jalr && w_rs1_link && !w_rd_link && w_ras_valid;

  fetch_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_enq && (w_is_jal || w_is_jalr) && w_rd_link),
    .pop       (w_enq && w_is_jalr && w_rs1_link),
    .push_data (w_pc4),
    .top       (w_ras_top),
    .valid     (w_ras_valid)
  );
`else
  assign w_ras_top = '0;
  assign w_ret_hit = 1'b0;
`endif

  always_comb begin
    w_next_pc = w_pc4;
    if (w_is_jal)       w_next_pc = w_jal_tgt;
    else if (w_ret_hit) w_next_pc = w_ras_top;
    else if (pred_hit)  w_next_pc = bht_out;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq && !w_deq)      w_count_nxt = r_count + 1'b1;
    else if (!w_enq && w_deq) w_count_nxt = r_count - 1'b1;
  end

  // A request is only outstanding in REQ/DROP, so the space test in IDLE ignores it.
  always_comb begin
    w_state_nxt = r_state;
    i_mem_read  = 1'b0;
    unique case (r_state)
      IDLE: if (!br_flush && (r_count < FULL)) w_state_nxt = REQ;
      REQ: begin
        i_mem_read = 1'b1;
        if (i_mem_resp) begin
          if (!br_flush && !(w_count_nxt < FULL)) w_state_nxt = IDLE;
        end else if (br_flush) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        i_mem_read = 1'b1;
        if (i_mem_resp) w_state_nxt = br_flush ? IDLE : REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      for (int i = 0; i < QDEPTH; i++) r_q[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (br_flush) begin
        r_pc    <= pc_mux_out;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        if ((r_state == REQ) && !i_mem_resp) r_drop_addr <= {r_pc[31:2], 2'b00};
      end else begin
        if (w_enq) begin
          r_q[r_tail] <= '{inst: i_mem_rdata, pc: r_pc, pred_pc: w_next_pc};
          r_tail      <= r_tail + 1'b1;
          r_pc        <= w_next_pc;
        end
        if (w_deq) r_head <= r_head + 1'b1;
        r_count <= w_count_nxt;
      end
    end
  end

  assign i_mem_addr  = (r_state == DROP) ? r_drop_addr : {r_pc[31:2], 2'b00};
  assign deq_valid   = (r_count != '0);
  assign deq_inst    = r_q[r_head].inst;
  assign deq_pc      = r_q[r_head].pc;
  assign deq_pred_pc = r_q[r_head].pred_pc;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - directed bench with a transaction-level fetch model
module tb_fetch_queue_stage;

  localparam int          QD   = 4;
  localparam int          RD   = 8;
  localparam logic [31:0] RPC  = 32'h6000_0000;
`ifdef FETCH_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk, rst, br_flush, pred_hit, i_mem_resp, i_mem_read, deq_ready, deq_valid;
  logic [31:0] pc_mux_out, bht_out, i_mem_rdata, i_mem_addr, deq_inst, deq_pc, deq_pred_pc;

  fetch_queue_stage #(.QDEPTH(QD), .RAS_DEPTH(RD), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .br_flush(br_flush), .pc_mux_out(pc_mux_out),
    .pred_hit(pred_hit), .bht_out(bht_out), .i_mem_rdata(i_mem_rdata),
    .i_mem_resp(i_mem_resp), .i_mem_addr(i_mem_addr), .i_mem_read(i_mem_read),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .deq_pred_pc(deq_pred_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem [logic [31:0]];
  bit          btb_en = 1'b0;
  logic [31:0] btb_pc = '0, btb_tgt = '0;

  ent_t        m_q [$];
  logic [31:0] m_ras [$];
  logic [31:0] m_pc = RPC, m_drop_addr = '0;
  bit          m_drop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0000_0013;
  endfunction

  function automatic bit lnk(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [31:0] jal_off(input logic [31:0] w);
    int off;
    off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
    if (w[31]) off = off - (1 << 20);
    return 32'(off);
  endfunction

  // Predicts bus address and queue head from fetch rules, then advances one cycle.
  task automatic model_step();
    ent_t        e;
    logic [31:0] w, nxt;
    bit          acc, jal, jalr;
    if (rst) begin
      m_q.delete();
      m_ras.delete();
      m_pc   = RPC;
      m_drop = 1'b0;
      return;
    end
    chk("m_addr", i_mem_addr, m_drop ? m_drop_addr : {m_pc[31:2], 2'b00});
    chk("m_valid", 32'(deq_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("m_inst", deq_inst, m_q[0].inst);
      chk("m_pc", deq_pc, m_q[0].pc);
      chk("m_pred", deq_pred_pc, m_q[0].pred);
    end
    if (i_mem_read) chk("m_space", 32'(m_q.size() < QD), 32'd1);
    acc = i_mem_read && i_mem_resp && !br_flush && !m_drop;
    if (!br_flush && deq_ready && m_q.size() != 0) void'(m_q.pop_front());
    if (acc) begin
      w    = i_mem_rdata;
      jal  = (w[6:0] == 7'h6f);
      jalr = (w[6:0] == 7'h67);
      if (jal) nxt = m_pc + jal_off(w);
      else if (RAS_EN && jalr && lnk(w[19:15]) && !lnk(w[11:7]) && m_ras.size() != 0)
        nxt = m_ras[$];
      else if (pred_hit) nxt = bht_out;
      else nxt = m_pc + 32'd4;
      if (RAS_EN) begin
        if (jalr && lnk(w[19:15]) && m_ras.size() != 0) void'(m_ras.pop_back());
        if ((jal || jalr) && lnk(w[11:7])) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > RD) void'(m_ras.pop_front());
        end
      end
      e.inst = w; e.pc = m_pc; e.pred = nxt;
      m_q.push_back(e);
      m_pc = nxt;
    end
    if (i_mem_read && i_mem_resp) m_drop = 1'b0;
    else if (br_flush && i_mem_read && !m_drop) begin
      m_drop      = 1'b1;
      m_drop_addr = {m_pc[31:2], 2'b00};
    end
    if (br_flush) begin
      m_q.delete();
      m_pc = pc_mux_out;
    end
  endtask

  // Zero-wait memory: answers a pending read in the same cycle, one beat every other cycle.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    i_mem_resp  = i_mem_read && !i_mem_resp;
    i_mem_rdata = mem_rd(i_mem_addr);
    pred_hit    = btb_en && (i_mem_addr == btb_pc);
    bht_out     = btb_tgt;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!i_mem_resp && n < 20) begin
      tick();
      n++;
    end
    chk("resp_seen", 32'(i_mem_resp), 32'd1);
  endtask

  task automatic expect_addr(input string nm, input logic [31:0] a);
    wait_resp();
    chk(nm, i_mem_addr, a);
    tick();
  endtask

  task automatic redirect(input logic [31:0] tgt);
    if (i_mem_resp) tick();
    br_flush   = 1'b1;
    pc_mux_out = tgt;
    tick();
    br_flush   = 1'b0;
    if (i_mem_resp) tick();
  endtask

  initial begin
    logic [31:0] old_addr;
    int          n;
    rst = 1'b1; br_flush = 1'b0; pc_mux_out = '0; pred_hit = 1'b0; bht_out = '0;
    i_mem_rdata = '0; i_mem_resp = 1'b0; deq_ready = 1'b1;
    repeat (3) tick();
    chk("rst_read", 32'(i_mem_read), 32'd0);
    chk("rst_addr", i_mem_addr, 32'h6000_0000);
    chk("rst_valid", 32'(deq_valid), 32'd0);
    chk("rst_inst", deq_inst, 32'd0);
    chk("rst_pc", deq_pc, 32'd0);
    chk("rst_pred", deq_pred_pc, 32'd0);

    rst = 1'b0;
    tick();
    chk("first_req", 32'(i_mem_read), 32'd1);
    for (int k = 0; k < 4; k++) begin
      expect_addr("seq_addr", 32'h6000_0000 + 32'(4 * k));
      if (k == 0) begin
        chk("seq_valid", 32'(deq_valid), 32'd1);
        chk("seq_pc", deq_pc, 32'h6000_0000);
        chk("seq_pred", deq_pred_pc, 32'h6000_0004);
      end
    end

    deq_ready = 1'b0;
    redirect(32'h6000_1000);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (i_mem_resp && i_mem_addr >= 32'h6000_1000) n++;
      tick();
    end
    chk("full_reqs", 32'(n), 32'd4);
    chk("full_read", 32'(i_mem_read), 32'd0);
    chk("full_valid", 32'(deq_valid), 32'd1);
    chk("full_head", deq_pc, 32'h6000_1000);
    deq_ready = 1'b1;
    expect_addr("resume_addr", 32'h6000_1010);

    old_addr   = i_mem_addr;
    br_flush   = 1'b1;
    pc_mux_out = 32'h6000_0200;
    tick();
    br_flush   = 1'b0;
    chk("drop_empty", 32'(deq_valid), 32'd0);
    chk("drop_hold", i_mem_addr, old_addr);
    tick();
    chk("drop_noenq", 32'(deq_valid), 32'd0);
    wait_resp();
    chk("flush_tgt", i_mem_addr, 32'h6000_0200);

    br_flush   = 1'b1;
    pc_mux_out = 32'h6000_0300;
    tick();
    br_flush   = 1'b0;
    chk("same_noenq", 32'(deq_valid), 32'd0);
    chk("same_req", 32'(i_mem_read), 32'd1);
    chk("same_pc", i_mem_addr, 32'h6000_0300);

    mem[32'h6000_0008] = 32'h0100_006f;
    redirect(32'h6000_0000);
    expect_addr("jal_a0", 32'h6000_0000);
    expect_addr("jal_a4", 32'h6000_0004);
    expect_addr("jal_a8", 32'h6000_0008);
    chk("jal_pred", deq_pred_pc, 32'h6000_0018);
    expect_addr("jal_tgt", 32'h6000_0018);

    mem.delete();
    mem[32'h6000_0000] = 32'h1000_00ef;
    mem[32'h6000_0100] = 32'h0000_8067;
    redirect(32'h6000_0000);
    expect_addr("call_addr", 32'h6000_0000);
    expect_addr("ret_addr", 32'h6000_0100);
    chk("ret_pred", deq_pred_pc, RAS_EN ? 32'h6000_0004 : 32'h6000_0104);
    expect_addr("ret_next", RAS_EN ? 32'h6000_0004 : 32'h6000_0104);

    btb_en = 1'b1; btb_pc = 32'h6000_0400; btb_tgt = 32'h6000_0500;
    redirect(32'h6000_0400);
    expect_addr("btb_src", 32'h6000_0400);
    expect_addr("btb_tgt", 32'h6000_0500);
    btb_en = 1'b0;

    rst = 1'b1;
    tick();
    chk("mid_rst_read", 32'(i_mem_read), 32'd0);
    chk("mid_rst_addr", i_mem_addr, 32'h6000_0000);
    chk("mid_rst_valid", 32'(deq_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_read", 32'(i_mem_read), 32'd1);
    chk("post_rst_addr", i_mem_addr, 32'h6000_0000);
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
